// File: rtl/layer_backprop.sv
// rtl/layer_backprop.sv - backward pass (dL/dx) and SGD weight update for one fully connected layer
// Optional feature macro: LAYER_BP_SAT_EN (saturating accumulation and weight update)
module layer_backprop #(
  parameter int INPUTS         = 3,
  parameter int OUTPUTS        = 2,
  parameter int INT_W          = 8,
  parameter int FRAC_W         = 8,
  parameter int NUM_W          = INT_W + FRAC_W,
  parameter int RAM_ADDR_W     = 8,
  parameter int RAM_ADDR_START = 0,
  parameter int RAM_DELAY      = 1,
  parameter int LR_SHIFT       = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            start_b,
  input  logic                            ready_b_in,
  input  logic [INPUTS-1:0][NUM_W-1:0]    inputs_f,
  input  logic [OUTPUTS-1:0][NUM_W-1:0]   inputs_b,
  output logic [INPUTS-1:0][NUM_W-1:0]    results_b,
  output logic                            ready_out,
  output logic                            mult_en,
  output logic [NUM_W-1:0]                mult_v1,
  output logic [NUM_W-1:0]                mult_v2,
  input  logic [NUM_W-1:0]                mult_res,
  output logic                            ram_write,
  output logic [RAM_ADDR_W-1:0]           ram_addr_write,
  output logic [NUM_W-1:0]                ram_data_write,
  output logic [RAM_ADDR_W-1:0]           ram_addr_read,
  input  logic [NUM_W-1:0]                ram_data_read
);

  localparam int I_W = $clog2(OUTPUTS + 1);
  localparam int J_W = $clog2(INPUTS + 2);
  localparam int C_W = $clog2(RAM_DELAY + 1);
  localparam logic [I_W-1:0]        I_LAST     = I_W'(OUTPUTS - 1);
  localparam logic [J_W-1:0]        J_LAST     = J_W'(INPUTS);
  localparam logic [C_W-1:0]        C_LAST     = C_W'(RAM_DELAY - 1);
  localparam logic [NUM_W-1:0]      ONE_FX     = NUM_W'(1) << FRAC_W;
  localparam logic [RAM_ADDR_W-1:0] ADDR_START = RAM_ADDR_W'(RAM_ADDR_START);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_GRAD, S_DIFF} state_t;

  // Signed add/subtract; clamps to the word range when saturation is built in, wraps otherwise.
  function automatic logic [NUM_W-1:0] add_sub(input logic [NUM_W-1:0] a,
                                               input logic [NUM_W-1:0] b,
                                               input logic             sub);
`ifdef LAYER_BP_SAT_EN
    logic [NUM_W:0] s;
    s = sub ? ({a[NUM_W-1], a} - {b[NUM_W-1], b}) : ({a[NUM_W-1], a} + {b[NUM_W-1], b});
    if (s[NUM_W] != s[NUM_W-1])
      add_sub = s[NUM_W] ? {1'b1, {(NUM_W-1){1'b0}}} : {1'b0, {(NUM_W-1){1'b1}}};
    else
      add_sub = s[NUM_W-1:0];
`else
    add_sub = sub ? (a - b) : (a + b);
`endif
  endfunction

  state_t                          state_q, state_d;
  logic [I_W-1:0]                  i_q, i_d;
  logic [J_W-1:0]                  j_q, j_d;
  logic [C_W-1:0]                  cnt_q, cnt_d;
  logic [INPUTS-1:0][NUM_W-1:0]    x_q, x_d;
  logic [OUTPUTS-1:0][NUM_W-1:0]   dy_q, dy_d;
  logic [INPUTS-1:0][NUM_W-1:0]    res_q, res_d;
  logic                            ready_q, ready_d;
  logic                            mult_en_q, mult_en_d;
  logic [NUM_W-1:0]                v1_q, v1_d, v2_q, v2_d;
  logic                            wr_q, wr_d;
  logic [RAM_ADDR_W-1:0]           addr_w_q, addr_w_d, addr_r_q, addr_r_d;
  logic [NUM_W-1:0]                data_w_q, data_w_d;
  logic [NUM_W-1:0]                dy_sel, x_sel, grad_sh;
  logic                            is_bias;

  // Operand selection for the current (i, j) element and the scaled gradient.
  always_comb begin
    dy_sel = '0;
    x_sel  = '0;
    for (int k = 0; k < OUTPUTS; k++)
      if (i_q == I_W'(k)) dy_sel = dy_q[k];
    for (int k = 0; k < INPUTS; k++)
      if (j_q == J_W'(k)) x_sel = x_q[k];
    is_bias = (j_q == J_LAST);
    grad_sh = NUM_W'($signed(mult_res) >>> LR_SHIFT);
  end

  // Next-state and next-output computation; nothing advances while enable is low.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    dy_d      = dy_q;
    res_d     = res_q;
    ready_d   = ready_q;
    mult_en_d = mult_en_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    wr_d      = wr_q;
    addr_w_d  = addr_w_q;
    addr_r_d  = addr_r_q;
    data_w_d  = data_w_q;
    if (enable) begin
      wr_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_b && ready_b_in && ready_q) begin
            x_d      = inputs_f;
            dy_d     = inputs_b;
            res_d    = '0;
            ready_d  = 1'b0;
            i_d      = '0;
            j_d      = '0;
            addr_r_d = ADDR_START;
            state_d  = S_READ;
          end
        end
        S_READ: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == C_LAST) begin
            state_d   = S_GRAD;
            mult_en_d = 1'b1;
            v1_d      = dy_sel;
            v2_d      = is_bias ? ONE_FX : x_sel;
          end else begin
            cnt_d = cnt_q + C_W'(1);
          end
        end
        S_GRAD: begin
          // Old weight is on the read port now; it feeds both dL/dx and the update.
          state_d   = S_DIFF;
          mult_en_d = !is_bias;
          v1_d      = ram_data_read;
          v2_d      = dy_sel;
          wr_d      = 1'b1;
          addr_w_d  = addr_r_q;
          data_w_d  = add_sub(ram_data_read, grad_sh, 1'b1);
        end
        S_DIFF: begin
          mult_en_d = 1'b0;
          v1_d      = '0;
          v2_d      = '0;
          for (int k = 0; k < INPUTS; k++)
            if (j_q == J_W'(k)) res_d[k] = add_sub(res_q[k], mult_res, 1'b0);
          if (is_bias && (i_q == I_LAST)) begin
            j_d     = '0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Weight block is contiguous, so the next element is always the next address.
            addr_r_d = addr_r_q + RAM_ADDR_W'(1);
            state_d  = S_READ;
            if (is_bias) begin
              j_d = '0;
              i_d = i_q + I_W'(1);
            end else begin
              j_d = j_q + J_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      dy_q      <= '0;
      res_q     <= '0;
      ready_q   <= 1'b1;
      mult_en_q <= 1'b0;
      v1_q      <= '0;
      v2_q      <= '0;
      wr_q      <= 1'b0;
      addr_w_q  <= ADDR_START;
      addr_r_q  <= ADDR_START;
      data_w_q  <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      dy_q      <= dy_d;
      res_q     <= res_d;
      ready_q   <= ready_d;
      mult_en_q <= mult_en_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      wr_q      <= wr_d;
      addr_w_q  <= addr_w_d;
      addr_r_q  <= addr_r_d;
      data_w_q  <= data_w_d;
    end
  end

  // A pending write or multiply is masked while frozen and replays once enable returns.
  assign ram_write      = wr_q & enable;
  assign mult_en        = mult_en_q & enable;
  assign mult_v1        = v1_q;
  assign mult_v2        = v2_q;
  assign ram_addr_write = addr_w_q;
  assign ram_data_write = data_w_q;
  assign ram_addr_read  = addr_r_q;
  assign results_b      = res_q;
  assign ready_out      = ready_q;

endmodule

// File: tb/tb_layer_backprop.sv
// tb/tb_layer_backprop.sv - directed-vector bench for layer_backprop
module tb_layer_backprop;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic              start_b = 1'b0;
  logic              ready_b_in = 1'b0;
  logic [2:0][15:0]  inputs_f;
  logic [1:0][15:0]  inputs_b;
  logic [2:0][15:0]  results_b;
  logic              ready_out, mult_en, ram_write;
  logic [15:0]       mult_v1, mult_v2, mult_res, ram_data_write;
  logic [15:0]       ram_data_read = 16'h0;
  logic [7:0]        ram_addr_write, ram_addr_read;
  logic signed [31:0] prod;

  logic [15:0] mem [0:255];
  int total = 0;
  int bad = 0;
  int write_cnt = 0;
  int busy_cnt = 0;
  int rise_cnt = 0;
  logic ready_prev = 1'b1;

  logic [15:0] w_orig [8] = '{16'h0000, 16'h0080, 16'hFF00, 16'h0180,
                              16'hFE00, 16'h0280, 16'hFD00, 16'h0380};
  logic [15:0] exp_row0 [8] = '{16'hFFF8, 16'h0068, 16'hFED8, 16'h0170,
                                16'hFE00, 16'h0280, 16'hFD00, 16'h0380};
  logic [15:0] exp_row1 [8] = '{16'h0000, 16'h0080, 16'hFF00, 16'h0180,
                                16'hFDF8, 16'h0268, 16'hFCD8, 16'h0370};
  logic [15:0] res_row0 [3] = '{16'h0000, 16'h0080, 16'hFF00};
  logic [15:0] res_row1 [3] = '{16'hFE00, 16'h0280, 16'hFD00};

  layer_backprop dut (
    .clk(clk), .reset(reset), .enable(enable), .start_b(start_b), .ready_b_in(ready_b_in),
    .inputs_f(inputs_f), .inputs_b(inputs_b), .results_b(results_b), .ready_out(ready_out),
    .mult_en(mult_en), .mult_v1(mult_v1), .mult_v2(mult_v2), .mult_res(mult_res),
    .ram_write(ram_write), .ram_addr_write(ram_addr_write), .ram_data_write(ram_data_write),
    .ram_addr_read(ram_addr_read), .ram_data_read(ram_data_read)
  );

  always #5 clk = ~clk;

  assign prod     = $signed(mult_v1) * $signed(mult_v2);
  assign mult_res = prod[23:8];

  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_addr_write] <= ram_data_write;
      write_cnt = write_cnt + 1;
    end
    ram_data_read <= mem[ram_addr_read];
  end

  always @(negedge clk) begin
    if (!ready_out) busy_cnt = busy_cnt + 1;
    if (ready_out && !ready_prev) rise_cnt = rise_cnt + 1;
    ready_prev = ready_out;
  end

  task automatic load_ram;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    for (int k = 0; k < 8; k++) mem[k] = w_orig[k];
    inputs_f = {16'h0280, 16'h0180, 16'h0080};
  endtask

  task automatic start_op(input logic [15:0] d0, input logic [15:0] d1);
    @(posedge clk);
    #1;
    inputs_b   = {d1, d0};
    write_cnt  = 0;
    busy_cnt   = 0;
    rise_cnt   = 0;
    start_b    = 1'b1;
    ready_b_in = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ready_out) break;
    end
    total++;
    if (ready_out !== 1'b1) begin
      $display("FAIL wait_done: ready_out=%b required 1 within 300 cycles", ready_out);
      bad++;
    end
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready_out !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", ready_out); bad++; end
    total++; if (results_b !== '0) begin $display("FAIL reset_results: got %h want 0", results_b); bad++; end
    total++; if (ram_write !== 1'b0 || mult_en !== 1'b0) begin
      $display("FAIL reset_strobes: ram_write=%b mult_en=%b want 0 0", ram_write, mult_en); bad++; end
    total++; if (ram_addr_read !== 8'h00 || ram_addr_write !== 8'h00) begin
      $display("FAIL reset_addrs: rd=%h wr=%h want 00 00", ram_addr_read, ram_addr_write); bad++; end
    total++; if (mult_v1 !== 16'h0 || mult_v2 !== 16'h0) begin
      $display("FAIL reset_operands: v1=%h v2=%h want 0 0", mult_v1, mult_v2); bad++; end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_row0;
    load_ram();
    start_op(16'h0100, 16'h0000);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      total++; if (results_b[k] !== res_row0[k]) begin
        $display("FAIL row0_results[%0d]: got %h want %h", k, results_b[k], res_row0[k]); bad++; end
    end
    for (int k = 0; k < 8; k++) begin
      total++; if (mem[k] !== exp_row0[k]) begin
        $display("FAIL row0_ram[%0d]: got %h want %h", k, mem[k], exp_row0[k]); bad++; end
    end
    total++; if (busy_cnt !== 32) begin $display("FAIL row0_busy: got %0d want 32", busy_cnt); bad++; end
    total++; if (write_cnt !== 8) begin $display("FAIL row0_writes: got %0d want 8", write_cnt); bad++; end
  endtask

  task automatic test_row1;
    load_ram();
    start_op(16'h0000, 16'h0100);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      total++; if (results_b[k] !== res_row1[k]) begin
        $display("FAIL row1_results[%0d]: got %h want %h", k, results_b[k], res_row1[k]); bad++; end
    end
    for (int k = 0; k < 8; k++) begin
      total++; if (mem[k] !== exp_row1[k]) begin
        $display("FAIL row1_ram[%0d]: got %h want %h", k, mem[k], exp_row1[k]); bad++; end
    end
  endtask

  task automatic test_zero_dy;
    load_ram();
    start_op(16'h0000, 16'h0000);
    wait_done();
    total++; if (results_b !== '0) begin $display("FAIL zero_results: got %h want 0", results_b); bad++; end
    for (int k = 0; k < 8; k++) begin
      total++; if (mem[k] !== w_orig[k]) begin
        $display("FAIL zero_ram[%0d]: got %h want %h", k, mem[k], w_orig[k]); bad++; end
    end
    total++; if (write_cnt !== 8) begin $display("FAIL zero_writes: got %0d want 8", write_cnt); bad++; end
  endtask

  task automatic test_busy_start;
    load_ram();
    start_op(16'h0100, 16'h0000);
    repeat (4) @(posedge clk);
    #1 start_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_b = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    total++; if (write_cnt !== 8) begin $display("FAIL busy_start_writes: got %0d want 8", write_cnt); bad++; end
    total++; if (rise_cnt !== 1) begin $display("FAIL busy_start_rises: got %0d want 1", rise_cnt); bad++; end
    total++; if (busy_cnt !== 32) begin $display("FAIL busy_start_busy: got %0d want 32", busy_cnt); bad++; end
    total++; if (mem[0] !== exp_row0[0] || mem[3] !== exp_row0[3]) begin
      $display("FAIL busy_start_ram: got %h %h want %h %h", mem[0], mem[3], exp_row0[0], exp_row0[3]); bad++; end
  endtask

  task automatic test_enable;
    int wr_before;
    int strobe_seen;
    load_ram();
    start_op(16'h0100, 16'h0000);
    repeat (11) @(posedge clk);
    #1 enable = 1'b0;
    wr_before   = write_cnt;
    strobe_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_write !== 1'b0 || mult_en !== 1'b0) strobe_seen++;
      @(posedge clk);
    end
    #1;
    total++; if (strobe_seen !== 0 || write_cnt !== wr_before) begin
      $display("FAIL enable_frozen: strobes=%0d writes=%0d want 0 and %0d", strobe_seen, write_cnt, wr_before); bad++; end
    enable = 1'b1;
    wait_done();
    total++; if (busy_cnt !== 37) begin $display("FAIL enable_busy: got %0d want 37", busy_cnt); bad++; end
    total++; if (write_cnt !== 8) begin $display("FAIL enable_writes: got %0d want 8", write_cnt); bad++; end
    for (int k = 0; k < 8; k++) begin
      total++; if (mem[k] !== exp_row0[k]) begin
        $display("FAIL enable_ram[%0d]: got %h want %h", k, mem[k], exp_row0[k]); bad++; end
    end
    for (int k = 0; k < 3; k++) begin
      total++; if (results_b[k] !== res_row0[k]) begin
        $display("FAIL enable_results[%0d]: got %h want %h", k, results_b[k], res_row0[k]); bad++; end
    end
  endtask

  task automatic test_reset_midop;
    load_ram();
    start_op(16'h0100, 16'h0000);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (ready_out !== 1'b1) begin $display("FAIL midreset_ready: got %b want 1", ready_out); bad++; end
    total++; if (results_b !== '0) begin $display("FAIL midreset_results: got %h want 0", results_b); bad++; end
    total++; if (ram_write !== 1'b0) begin $display("FAIL midreset_write: got %b want 0", ram_write); bad++; end
    @(posedge clk);
    #1 reset = 1'b0;
    load_ram();
    start_op(16'h0100, 16'h0000);
    wait_done();
    total++; if (busy_cnt !== 32) begin $display("FAIL midreset_busy: got %0d want 32", busy_cnt); bad++; end
    total++; if (results_b[2] !== res_row0[2]) begin
      $display("FAIL midreset_results2: got %h want %h", results_b[2], res_row0[2]); bad++; end
  endtask

  task automatic test_saturation;
    logic [15:0] exp_w0;
`ifdef LAYER_BP_SAT_EN
    exp_w0 = 16'h7FFF;
`else
    exp_w0 = 16'h87E0;
`endif
    load_ram();
    mem[0]      = 16'h7FF0;
    inputs_f[0] = 16'h7F00;
    start_op(16'hFF00, 16'h0000);
    wait_done();
    total++; if (mem[0] !== exp_w0) begin $display("FAIL sat_w0: got %h want %h", mem[0], exp_w0); bad++; end
    total++; if (results_b[0] !== 16'h8010) begin
      $display("FAIL sat_results0: got %h want 8010", results_b[0]); bad++; end
  endtask

  initial begin
    inputs_f = {16'h0280, 16'h0180, 16'h0080};
    inputs_b = '0;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    test_reset();
    test_row0();
    test_row1();
    test_zero_dy();
    test_busy_start();
    test_enable();
    test_reset_midop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
